// File: rtl/multdiv_pkg.sv
// Shared multdiv definitions: data width, INT_MIN and the add/sub op encoding
// used by both the divider control FSM and the divider datapath.
package multdiv_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } div_op_e;

endpackage

// File: rtl/div_datapath_if.sv
// Control/processor <-> divider datapath bundle. The remainder signal exists
// only when DIV_REMAINDER_OUT_EN is defined.
interface div_datapath_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             add;
  logic             sub;
  logic             shift_quotient;
  logic             ready;
  logic             msb;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             result_rdy;
`ifdef DIV_REMAINDER_OUT_EN
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor, add, sub, shift_quotient, ready,
    input  msb, result, exception, result_rdy, remainder
  );

  modport slave (
    input  start, dividend, divisor, add, sub, shift_quotient, ready,
    output msb, result, exception, result_rdy, remainder
  );
`else
  modport master (
    output start, dividend, divisor, add, sub, shift_quotient, ready,
    input  msb, result, exception, result_rdy
  );

  modport slave (
    input  start, dividend, divisor, add, sub, shift_quotient, ready,
    output msb, result, exception, result_rdy
  );
`endif

endinterface

// File: rtl/div_datapath_add_sub_n.sv
// N-bit combinational adder/subtractor: y = a + b, or a - b via invert-and-carry-in.
module add_sub_n #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] y_o
);

  assign y_o = a_i + (b_i ^ {N{sub_i}}) + N'(sub_i);

endmodule

// File: rtl/div_datapath.sv
// Non-restoring signed divider datapath, one iteration per control strobe.
// Define DIV_REMAINDER_OUT_EN to add the corrected, sign-fixed remainder output.
module div_datapath
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  div_datapath_if.slave bus
);

  localparam int AW = WIDTH + 1;

  logic [AW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             negq_q, negq_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  div_op_e          op;
  logic [AW-1:0]    t;
  logic [AW-1:0]    a_t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // Subtract wins if the control ever raises both strobes.
  always_comb begin
    if (bus.sub)      op = OP_SUB;
    else if (bus.add) op = OP_ADD;
    else              op = OP_NONE;
  end

  assign t = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

  add_sub_n #(.N(AW)) u_iter (
    .a_i   (t),
    .b_i   ((op == OP_NONE) ? '0 : {1'b0, m_q}),
    .sub_i (op == OP_SUB),
    .y_o   (a_t)
  );

`ifdef DIV_REMAINDER_OUT_EN
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [AW-1:0]    a_fix;
  logic [WIDTH-1:0] r_mag;

  // A negative final accumulator is restored by adding the divisor back once.
  add_sub_n #(.N(AW)) u_fix (
    .a_i   (a_q),
    .b_i   ({1'b0, m_q}),
    .sub_i (1'b0),
    .y_o   (a_fix)
  );

  assign r_mag         = a_q[WIDTH] ? a_fix[WIDTH-1:0] : a_q[WIDTH-1:0];
  assign bus.remainder = rem_q;
`endif

  // NOTE: every next-state signal gets a default first, so no latch is inferred.
  always_comb begin
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    negq_d   = negq_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
    negr_d   = negr_q;
    rem_d    = rem_q;
`endif
    if (bus.start) begin
      a_d    = '0;
      q_d    = mag(bus.dividend);
      m_d    = mag(bus.divisor);
      negq_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      dz_d   = (bus.divisor == '0);
      busy_d = 1'b1;
`ifdef DIV_REMAINDER_OUT_EN
      negr_d = bus.dividend[WIDTH-1];
`endif
    end else if (busy_q && bus.ready) begin
      result_d = dz_q ? '0 : (negq_q ? -q_q : q_q);
      exc_d    = dz_q;
      rdy_d    = 1'b1;
      busy_d   = 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
      rem_d    = dz_q ? '0 : (negr_q ? -r_mag : r_mag);
`endif
    end else if (busy_q && bus.shift_quotient) begin
      a_d = a_t;
      q_d = {q_q[WIDTH-2:0], ~a_t[WIDTH]};
    end
  end

  // NOTE: reset is synchronous and clears every register; state updates use <= only.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      negq_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef DIV_REMAINDER_OUT_EN
      negr_q   <= 1'b0;
      rem_q    <= '0;
`endif
    end else begin
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      negq_q   <= negq_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
`ifdef DIV_REMAINDER_OUT_EN
      negr_q   <= negr_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign bus.msb        = a_q[WIDTH];
  assign bus.result     = result_q;
  assign bus.exception  = exc_q;
  assign bus.result_rdy = rdy_q;

endmodule

// File: tb/tb_div_datapath.sv
// Scoreboard bench for div_datapath: the bench plays the control FSM, expected
// quotients come from plain signed arithmetic, a monitor checks each result_rdy.
module tb_div_datapath;
  import multdiv_pkg::*;

  localparam int W = DATA_WIDTH;

  typedef struct {
    logic [W-1:0] q;
    logic         exc;
    logic [W-1:0] rem;
    int           cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  div_datapath_if bus ();

  div_datapath dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sd;
    if (b == '0) return '0;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    return W'(sa / sd);
  endfunction

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sd;
    if (b == '0) return '0;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    return W'(sa % sd);
  endfunction

  // Monitor: every result_rdy pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.result_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_result_rdy", W'(bus.result_rdy), '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result, e.q);
        check("exception", W'(bus.exception), W'(e.exc));
        check("rdy_latency", W'(cyc), W'(e.cyc));
`ifdef DIV_REMAINDER_OUT_EN
        check("remainder", bus.remainder, e.rem);
`endif
      end
    end
  end

  always @(negedge clock) begin
    if (bus.shift_quotient) assert (!(bus.add && bus.sub)) else $error("add and sub both asserted");
  end

  task automatic ctl(input logic s, input logic r, input logic sh, input logic ad, input logic su);
    @(negedge clock);
    bus.start          = s;
    bus.ready          = r;
    bus.shift_quotient = sh;
    bus.add            = ad;
    bus.sub            = su;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic with_ready);
    ctl(1'b1, with_ready, 1'b0, 1'b0, 1'b0);
    bus.dividend = a;
    bus.divisor  = b;
  endtask

  // Control behaviour: sub first, then add/sub from the previous remainder sign.
  task automatic iterate(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      bus.start          = 1'b0;
      bus.ready          = 1'b0;
      bus.shift_quotient = 1'b1;
      bus.add            = bus.msb;
      bus.sub            = ~bus.msb;
      bus.dividend       = $urandom;
      bus.divisor        = $urandom;
    end
  endtask

  task automatic ready_expect(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e.q   = ref_quot(a, b);
    e.exc = (b == '0);
    e.rem = ref_rem(a, b);
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // Idle cycles; with junk set, random strobes that an idle datapath must ignore.
  task automatic idle(input int n, input logic junk);
    for (int i = 0; i < n; i++) begin
      logic j_add;
      j_add = junk & 1'($urandom_range(0, 1));
      ctl(1'b0, junk & 1'($urandom_range(0, 1)), junk & 1'($urandom_range(0, 1)),
          j_add, junk & ~j_add & 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(a, b, 1'b0);
    iterate(W);
    ready_expect(a, b);
    idle(2, 1'b1);
  endtask

  function automatic logic [W-1:0] rand_operand(input bit allow_zero);
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = INT_MIN;
      1:       v = '1;
      2:       v = W'($urandom_range(1, 1000));
      3:       v = -W'($urandom_range(1, 1000));
      default: v = $urandom;
    endcase
    if (!allow_zero && v == '0) v = 1;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.ready = 1'b0; bus.shift_quotient = 1'b0;
    bus.add = 1'b0; bus.sub = 1'b0; bus.dividend = '0; bus.divisor = '0;

    repeat (3) @(negedge clock);
    check("reset_msb", W'(bus.msb), '0);
    check("reset_result", bus.result, '0);
    check("reset_exception", W'(bus.exception), '0);
    check("reset_result_rdy", W'(bus.result_rdy), '0);
    reset = 1'b0;

    run_div(32'd100, 32'd7);
    run_div(-32'd100, 32'd7);
    run_div(32'd100, -32'd7);
    run_div(-32'd100, -32'd7);
    run_div(32'd5, 32'd0);
    run_div(INT_MIN, 32'hFFFF_FFFF);
    run_div(INT_MIN, 32'd1);

    // Reset in the middle of a divide: the later ready pulse must be ignored.
    start_op(32'd100, 32'd7, 1'b0);
    iterate(10);
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("rst_mid_msb", W'(bus.msb), '0);
    check("rst_mid_result", bus.result, '0);
    check("rst_mid_exception", W'(bus.exception), '0);
    check("rst_mid_result_rdy", W'(bus.result_rdy), '0);

    // A new start aborts the divide in flight; only the new one reports.
    start_op(32'd50, 32'd3, 1'b0);
    iterate(10);
    run_div(32'd100, 32'd7);

    // Start and ready in the same cycle: start wins, no result for the old op.
    start_op(32'd50, 32'd3, 1'b0);
    iterate(W);
    start_op(32'd100, 32'd7, 1'b1);
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_ready_no_rdy", W'(bus.result_rdy), '0);
    iterate(W);
    ready_expect(32'd100, 32'd7);
    idle(2, 1'b1);

    for (int k = 0; k < 40; k++) begin
      run_div(rand_operand(1'b1), ($urandom_range(0, 9) == 0) ? '0 : rand_operand(1'b0));
    end

    idle(3, 1'b0);
    check("scoreboard_drained", W'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
